// File: rtl/quad_match_pkg.sv
// Shared types, default sizes and index-width helper for the quadrant matcher.
package quad_match_pkg;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned W_DEFAULT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MATCH,
    S_DONE
  } state_e;

  // Width of one map index; at least one bit so the ports never collapse.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/match_pick.sv
// Lowest-index free-and-equal search of one value against the target group.
module match_pick
  import quad_match_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [W-1:0]   value_i,
  input  logic [N*W-1:0] b_i,
  input  logic [N-1:0]   used_i,
  output logic           found_o,
  output logic [IW-1:0]  idx_o
);

  // Priority encoder: the first hit in ascending order wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (!found_o && !used_i[j] && (b_i[j*W +: W] == value_i)) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/quad_match_seq.sv
// Sequential A-to-B matcher: one A element per cycle against a used mask over B,
// groups exchanged through valid/ready handshakes on both sides.
module quad_match_seq
  import quad_match_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*W-1:0]               in_a,
  input  logic [N*W-1:0]               in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*idx_width(N)-1:0]    out_map,
  output logic [N-1:0]                 out_miss,
  output logic                         out_ok,
  output logic                         busy
);

  localparam int unsigned IW = idx_width(N);

  state_e            state_q, state_d;
  logic [IW-1:0]     k_q, k_d;
  logic [N-1:0]      used_q, used_d;
  logic [N*IW-1:0]   map_q, map_d;
  logic [N-1:0]      miss_q, miss_d;
  logic [N*W-1:0]    a_q, a_d;
  logic [N*W-1:0]    b_q, b_d;

  logic [W-1:0]      cur_a;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  assign cur_a = a_q[k_q*W +: W];

  match_pick #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) u_pick (
    .value_i (cur_a),
    .b_i     (b_q),
    .used_i  (used_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      used_q  <= '0;
      map_q   <= '0;
      miss_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      used_q  <= used_d;
      map_q   <= map_d;
      miss_q  <= miss_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state: latch on input handshake, one match step per cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    used_d  = used_q;
    map_d   = map_q;
    miss_d  = miss_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          used_d  = '0;
          map_d   = '0;
          miss_d  = '0;
          k_d     = '0;
          state_d = S_MATCH;
        end
      end
      S_MATCH: begin
        if (pick_found) begin
          map_d[k_q*IW +: IW] = pick_idx;
          used_d[pick_idx]    = 1'b1;
          miss_d[k_q]         = 1'b0;
        end else begin
          // A miss leaves the used mask alone so later elements can still match.
          map_d[k_q*IW +: IW] = '0;
          miss_d[k_q]         = 1'b1;
        end
        if (k_q == IW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags decode straight from state; no DONE-to-IDLE bypass.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out_map   = map_q;
    out_miss  = miss_q;
    out_ok    = ~|miss_q;
  end

endmodule

// File: doc/quad_match_seq.md
Name: quad_match_seq

Overview:
- Sequential controller that computes the quadrant-to-quadrant matching map between a source group A and a target group B.
- Processes one A element per cycle against a running "used" mask over B.
- Exchanges whole groups through valid/ready handshakes, so it sits between the shape-decode stage and the swap/rotate stage that consumes the permutation.
- Replaces a flat combinational matcher on timing-critical paths and adds explicit miss reporting for elements with no free target.

Parameters:
- N, 4, number of elements per group (quadrants); must be ≥ 2.
- W, 2, width of one element value.
- IW, $clog2(N), width of one map index; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low (sampled on the rising edge of clk).
- in_valid  input  1  A/B group offered.
- in_ready  output  1  block can accept a group; high only in IDLE.
- in_a  input  N*W  source elements; element k at [k*W +: W].
- in_b  input  N*W  target elements; element j at [j*W +: W].
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_map  output  N*IW  map[k] = index in B assigned to A[k], at [k*IW +: IW].
- out_miss  output  N  miss[k] = 1 when A[k] found no free equal element in B.
- out_ok  output  1  all elements matched; equals ~|out_miss.
- busy  output  1  state != IDLE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - MATCH: step counter k runs 0..N-1.
  - DONE: out_valid=1.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE, k=0, used mask=0, out_map=0, out_miss=0.
  - out_valid=0, busy=0, in_ready=1 from the next cycle.
  - Reset mid-MATCH or mid-DONE abandons the group silently; no output is produced for it.
- IDLE:
  - in_valid & in_ready at edge t latches in_a and in_b, clears the used mask, map and miss, sets k=0, and moves to MATCH.
  - Input changes after the handshake have no effect.
- MATCH, one step per cycle:
  - Select j = lowest index with B[j]==A[k] and used[j]==0.
  - If found: map[k]=j, used[j]=1, miss[k]=0.
  - If none: map[k]=0, miss[k]=1, used mask unchanged.
  - A miss never consumes a B element.
  - Priority is strictly lowest-index-first.
  - When k==N-1 the next state is DONE; otherwise k increments.
- Latency:
  - Input handshake at edge t gives out_valid=1 in the cycle after edge t+N.
  - Latency is exactly N+1 cycles handshake-to-valid, independent of data.
- DONE:
  - out_map, out_miss and out_ok are stable while out_valid=1.
  - out_valid & out_ready at an edge moves to IDLE, and out_valid drops next cycle.
  - Held indefinitely while out_ready=0 (backpressure).
- No bypass: in_ready=0 in DONE, even if out_ready=1 in the same cycle. The minimum group period is N+2 cycles.
- Outputs in IDLE and MATCH:
  - out_map and out_miss hold the last result (0 after reset).
  - Consumers sample them only when out_valid=1.
- Duplicates: equal values in A are assigned to equal-valued B positions in ascending order of both indices.
- Unmatched B elements need no flag; the consumer derives them from map/miss if needed.

Decomposition:
- Package quad_match_pkg holds:
  - The state enum {S_IDLE, S_MATCH, S_DONE}.
  - Default N=4 and W=2 localparams.
  - A function returning IW from N.
- Sub-module match_pick (combinational, parameterised N/W) with:
  - Inputs: value, B vector, used mask.
  - Outputs: found, index (lowest-index priority encoder).
  - It is instantiated once; the FSM, counter and registers live in quad_match_seq.

Test Plan:
- Permutation: A={1,2,3,0}, B={0,1,2,3} → map={1,2,3,0}, miss=0000, ok=1, out_valid exactly 5 cycles after the handshake.
- Duplicates: A={2,2,1,1}, B={1,2,1,2} → map={1,3,0,2}, miss=0000, ok=1.
- Miss without consumption: A={3,0,0,0}, B={0,0,0,0} → map={0,0,1,2}, miss[0..3]={1,0,0,0}, ok=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0; the out_ready pulse leads to in_ready=1 the next cycle.
- Back-to-back: keep in_valid=1 with two groups → second handshake is exactly 1 cycle after the first output handshake; no result mixing.
- Reset mid-MATCH: rst_n=0 at k=2 → next cycle IDLE, in_ready=1, out_valid=0, out_map=0, out_miss=0; a new group then completes normally.
